// File: rtl/arith_pkg.sv
// arith_pkg: shared arithmetic-unit constants and divider FSM encoding
package arith_pkg;
  localparam int DEF_PROC_SIZE = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division step producing the next partial remainder and quotient bit
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] r,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_next,
  output logic         q_bit
);
  logic [W:0] r_sh;
  logic [W:0] t;
  // r_sh keeps the bit shifted out of r, so t[W] is the borrow
  assign r_sh   = {r, q_msb};
  assign t      = r_sh - {1'b0, divisor};
  assign q_bit  = ~t[W];
  assign r_next = t[W] ? r_sh[W-1:0] : t[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned multi-cycle restoring divider with start/busy/done handshake
module seq_divider
  import arith_pkg::*;
#(
  parameter int PROC_SIZE = DEF_PROC_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PROC_SIZE-1:0] dividend,
  input  logic [PROC_SIZE-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [PROC_SIZE-1:0] quotient,
  output logic [PROC_SIZE-1:0] remainder,
  output logic                 div_by_zero
);
  localparam int CW = $clog2(PROC_SIZE) + 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [PROC_SIZE-1:0] r, q, dvs, r_nxt;
  logic q_bit, last, zero;
  div_step #(.W(PROC_SIZE)) u_step (
    .r(r),
    .q_msb(q[PROC_SIZE-1]),
    .divisor(dvs),
    .r_next(r_nxt),
    .q_bit(q_bit)
  );
  assign last = cnt == CW'(PROC_SIZE - 1);
  assign zero = divisor == '0;
  assign busy = state != IDLE;
  assign done = state == FIN;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? (zero ? FIN : CALC) : IDLE) :
                state == CALC ? (last ? FIN : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt         <= '0;
      r           <= '0;
      q           <= dividend;
      dvs         <= divisor;
      div_by_zero <= zero;
      if (zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      r   <= r_nxt;
      q   <= {q[PROC_SIZE-2:0], q_bit};
      if (last) begin
        quotient  <= {q[PROC_SIZE-2:0], q_bit};
        remainder <= r_nxt;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard-driven self-checking bench for seq_divider
module tb_seq_divider;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  exp_t sb[$];
  int checks = 0, errors = 0;
  seq_divider #(.PROC_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;

  // drive one start pulse; the accepting edge is the posedge inside this task
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit push);
    exp_t e;
    e.dz  = (b == 0);
    e.q   = e.dz ? 16'hFFFF : a / b;
    e.r   = e.dz ? a : a % b;
    e.lat = e.dz ? 0 : 16;
    start = 1'b1; dividend = a; divisor = b;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = b + 16'd3;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b q=%h r=%h dz=%b, want all 0", busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] ta[6] = '{16'd100, 16'hFFFF, 16'd3, 16'd5, 16'hFFFE, 16'd40000};
    logic [15:0] tb[6] = '{16'd7, 16'd1, 16'd10, 16'd0, 16'hFFFF, 16'd40001};
    int lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_accept[%0d]: got %b want 1", i, busy);
      end
      wait_done(0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      checks++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        errors++;
        $display("FAIL result[%0d] %0d/%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, ta[i], tb[i], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q) begin
        errors++;
        $display("FAIL idle_after_done[%0d]: got done=%b busy=%b q=%h want 0 0 %h", i, done, busy, quotient, e.q);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    exp_t e;
    start_op(16'd100, 16'd7, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 16 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d", lat, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort;
    int lat;
    int seen = 0;
    exp_t e;
    start_op(16'd100, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, quotient, remainder, div_by_zero);
    end
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
      if (seen == 0 && $time > 0) rst_n = 1'b1;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done_pulses=%0d busy=%b want 0 0", seen, busy);
    end
    start_op(16'd9, 16'd3, 1'b1);
    wait_done(0, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 16 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL after_abort: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d", lat, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    exp_t e;
    start_op(16'd200, 16'd9, 1'b1);
    wait_done(0, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 16 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d", lat, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    start_op(16'd50, 16'd5, 1'b1);
    checks++;
    if (busy !== 1'b1 || quotient !== e.q) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b q=%0d want busy=1 q=%0d", busy, quotient, e.q);
    end
    wait_done(0, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 16 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d", lat, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat;
    exp_t e;
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(16'hFFFF, 16'h8000)) : 16'($urandom_range(16'hFF, 0));
      start_op(a, b, 1'b1);
      wait_done(0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b", i, a, b, lat, quotient, remainder, div_by_zero, e.lat, e.q, e.r, e.dz);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
